// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// UART_TX_PARITY_EN selects an 8E1 frame instead of 8N1.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int UART_DATA_W = 8;

`ifdef UART_TX_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO with registered full/empty flags and first-word fall-through read data.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_wr;
    logic             do_rd;

    // The registered full flag gates writes, so a push while full is dropped even if a pop happens.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + CW'(1);
        end else if (!do_wr && do_rd) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_transmitter.sv
// Buffered UART transmitter: TX FIFO feeding a baud-timed serialiser (8N1, LSB first).
// Defining UART_TX_PARITY_EN adds an even-parity bit (8E1).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic [UART_DATA_W-1:0] data,
    output logic                   done,
    output logic                   full,
    output logic                   tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BW           = $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_transmitter: CLK_FREQ_HZ/BAUD_RATE must be >= 4");
    end

    tx_state_t              state;
    logic [BW-1:0]          baud_cnt;
    logic [2:0]             bit_cnt;
    logic [UART_DATA_W-1:0] shift;
    logic [UART_DATA_W-1:0] fifo_data;
    logic                   fifo_empty;
    logic                   baud_last;
    logic                   pop;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    uart_tx_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (valid),
        .wr_data (data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (fifo_empty)
    );

    assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    // Popping at the end of STOP chains frames with no idle gap.
    assign pop = !fifo_empty && ((state == IDLE) || (state == STOP && baud_last));

    // tx is a registered copy of the current state's line level, so it trails the state by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= fifo_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_data;
`endif
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (baud_last) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx <= parity_bit;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        done     <= 1'b1;
                        if (pop) begin
                            shift    <= fifo_data;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^fifo_data;
`endif
                            bit_cnt  <= '0;
                            state    <= START;
                        end else begin
                            state    <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
